vending_input_conditioner: RTL and testbench

Front-end stage for `vending_machine`. It takes the raw board push-buttons (coin inserts, drink selects, refund), synchronises and debounces each one, and turns every clean press into a single-cycle pulse. At most one pulse leaves per clock, with fixed-priority arbitration and per-channel pending buffering, so the downstream T-flip-flop state machine sees one well-formed event per cycle.

---
 rtl/vending_input_conditioner.sv | 142 ++++++++++++++
 tb/tb_vending_input_conditioner.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vending_input_conditioner.sv
// Button front-end: optional 2-flop sync, debounce, press detect, one-pulse-per-clock arbiter.
// Optional feature macro: VENDING_INPUT_SYNC_EN (2-flop synchroniser on every raw input).

module vending_input_channel #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw_i,
  input  logic grant_i,
  output logic pend_o,
  output logic pend_d_o
);

  logic             s;
  logic             d_q, d_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             p_q, p_d;
  logic             rise;

`ifdef VENDING_INPUT_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[0], raw_i};
  end

  assign s = sync_q[1];
`else
  assign s = raw_i;
`endif

  // Any sample agreeing with the current level restarts the stability count.
  always_comb begin
    d_d   = d_q;
    cnt_d = cnt_q;
    if (s == d_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      d_d   = s;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign rise = ~d_q & d_d;

  // A press arriving while one is already pending is absorbed.
  always_comb begin
    p_d = p_q;
    if (p_q) begin
      if (grant_i) p_d = 1'b0;
    end else if (rise) begin
      p_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d_q   <= 1'b0;
      cnt_q <= '0;
      p_q   <= 1'b0;
    end else begin
      d_q   <= d_d;
      cnt_q <= cnt_d;
      p_q   <= p_d;
    end
  end

  assign pend_o   = p_q;
  assign pend_d_o = p_d;

endmodule

module vending_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] moneyin_raw,
  input  logic [3:0] buy_raw,
  input  logic       refund_raw,
  output logic [3:0] moneyin,
  output logic [3:0] buy,
  output logic       refund,
  output logic       event_pending
);

  localparam int NUM_CH = 9;

  // Channel index doubles as priority: bit 8 (refund) highest, bit 0 (buy[0]) lowest.
  logic [NUM_CH-1:0] raw_all;
  logic [NUM_CH-1:0] pend;
  logic [NUM_CH-1:0] pend_d;
  logic [NUM_CH-1:0] gnt;
  logic [NUM_CH-1:0] out_q;
  logic              evp_q;

  assign raw_all = {refund_raw, moneyin_raw, buy_raw};

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    vending_input_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_ch (
      .clk     (clk),
      .reset_n (reset_n),
      .raw_i   (raw_all[c]),
      .grant_i (gnt[c]),
      .pend_o  (pend[c]),
      .pend_d_o(pend_d[c])
    );
  end

  // Later (higher) indices overwrite earlier ones, leaving the highest set bit.
  always_comb begin
    gnt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (pend[i]) gnt = NUM_CH'(1) << i;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q <= '0;
      evp_q <= 1'b0;
    end else begin
      out_q <= gnt;
      evp_q <= |pend_d;
    end
  end

  assign refund        = out_q[8];
  assign moneyin       = out_q[7:4];
  assign buy           = out_q[3:0];
  assign event_pending = evp_q;

endmodule

// File: tb/tb_vending_input_conditioner.sv
// Randomised + directed bench for vending_input_conditioner against a sample-history model.
module tb_vending_input_conditioner;

  localparam int N   = 4;
  localparam int NCH = 9;
`ifdef VENDING_INPUT_SYNC_EN
  localparam int SYNC_DLY = 2;
`else
  localparam int SYNC_DLY = 0;
`endif
  localparam int LAT = N + SYNC_DLY;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] moneyin_raw, buy_raw;
  logic       refund_raw;
  logic [3:0] moneyin, buy;
  logic       refund, event_pending;

  int checks = 0;
  int fails  = 0;

  // Model state, indexed by priority rank (0 = refund ... 8 = buy[0]).
  logic [NCH-1:0] m_hist [SYNC_DLY+1];
  logic [NCH-1:0] m_lvl, m_pend, exp_pulse;
  logic           exp_evp;
  int             m_run [NCH];

  vending_input_conditioner #(.DEBOUNCE_CYCLES(N), .CNT_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .moneyin_raw(moneyin_raw), .buy_raw(buy_raw),
    .refund_raw(refund_raw), .moneyin(moneyin), .buy(buy), .refund(refund),
    .event_pending(event_pending)
  );

  always #5 clk = ~clk;

  function automatic logic [NCH-1:0] raw_pr();
    logic [NCH-1:0] r;
    r[0] = refund_raw;
    for (int i = 0; i < 4; i++) begin
      r[1+i] = moneyin_raw[3-i];
      r[5+i] = buy_raw[3-i];
    end
    return r;
  endfunction

  function automatic logic [NCH-1:0] obs();
    logic [NCH-1:0] o;
    o[0] = refund;
    for (int i = 0; i < 4; i++) begin
      o[1+i] = moneyin[3-i];
      o[5+i] = buy[3-i];
    end
    return o;
  endfunction

  task automatic model_reset();
    for (int k = 0; k <= SYNC_DLY; k++) m_hist[k] = '0;
    for (int k = 0; k < NCH; k++) m_run[k] = 0;
    m_lvl = '0; m_pend = '0; exp_pulse = '0; exp_evp = 1'b0;
  endtask

  // Level flips after N consecutive samples disagreeing with it; rank order picks the winner.
  task automatic model_step();
    logic [NCH-1:0] s, acc, g;
    if (!reset_n) begin
      model_reset();
      return;
    end
    for (int k = SYNC_DLY; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = raw_pr();
    s   = m_hist[SYNC_DLY];
    acc = '0;
    for (int k = 0; k < NCH; k++) begin
      if (s[k] != m_lvl[k]) begin
        m_run[k]++;
        if (m_run[k] == N) begin
          m_lvl[k] = s[k];
          m_run[k] = 0;
          acc[k]   = s[k];
        end
      end else begin
        m_run[k] = 0;
      end
    end
    g = '0;
    for (int k = NCH - 1; k >= 0; k--) if (m_pend[k]) g = '0 | (NCH'(1) << k);
    m_pend    = (m_pend & ~g) | (acc & ~m_pend);
    exp_pulse = g;
    exp_evp   = |m_pend;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    moneyin_raw = '0; buy_raw = '0; refund_raw = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    moneyin_raw = 4'hf; buy_raw = 4'hf; refund_raw = 1'b1;
    model_reset();
    for (int t = 0; t < 3; t++) begin
      tick();
      checks++;
      if ({refund, moneyin, buy, event_pending} !== 10'b0) begin
        fails++;
        $display("FAIL reset t=%0d: got %b want 0", t, {refund, moneyin, buy, event_pending});
      end
    end
    reset_n = 1'b1;
    idle(2 * LAT + 4);
  endtask

  task automatic test_clean_press();
    int np = 0;
    moneyin_raw = 4'b0001;
    for (int t = 0; t < LAT + 6; t++) begin
      if (t == 10) moneyin_raw = 4'b0000;
      tick();
      np += $countones(obs());
      checks++;
      if (obs() !== exp_pulse || event_pending !== exp_evp) begin
        fails++;
        $display("FAIL clean_press t=%0d: out=%b evp=%b want %b %b", t, obs(), event_pending, exp_pulse, exp_evp);
      end
      if (t == LAT - 1 || t == LAT) begin
        checks++;
        if (event_pending !== (t == LAT - 1) || moneyin !== ((t == LAT) ? 4'b0001 : 4'b0000)) begin
          fails++;
          $display("FAIL clean_press_timing t=%0d: moneyin=%b evp=%b", t, moneyin, event_pending);
        end
      end
    end
    checks++;
    if (np != 1) begin fails++; $display("FAIL clean_press_count: got %0d want 1", np); end
    idle(2 * LAT + 4);
  endtask

  task automatic test_bounce();
    int np = 0;
    for (int t = 0; t < LAT + 12; t++) begin
      buy_raw[2] = (t < 4) ? (t % 2 == 0) : 1'b1;
      tick();
      np += $countones(obs());
      checks++;
      if (obs() !== exp_pulse || buy !== ((t == 4 + LAT) ? 4'b0100 : 4'b0000)) begin
        fails++;
        $display("FAIL bounce t=%0d: out=%b buy=%b want %b", t, obs(), buy, exp_pulse);
      end
    end
    checks++;
    if (np != 1) begin fails++; $display("FAIL bounce_count: got %0d want 1", np); end
    idle(2 * LAT + 4);
  endtask

  task automatic test_glitch();
    for (int t = 0; t < 14; t++) begin
      refund_raw = (t < 3);
      tick();
      checks++;
      if (refund !== 1'b0 || event_pending !== 1'b0 || obs() !== exp_pulse) begin
        fails++;
        $display("FAIL glitch t=%0d: refund=%b evp=%b want 0 0", t, refund, event_pending);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [NCH-1:0] want;
    refund_raw = 1'b1; moneyin_raw = 4'b1000; buy_raw = 4'b0001;
    for (int t = 0; t < LAT + 6; t++) begin
      tick();
      want = (t == LAT) ? 9'b000000001 : (t == LAT + 1) ? 9'b000000010 :
             (t == LAT + 2) ? 9'b100000000 : 9'b0;
      checks++;
      if (obs() !== want || obs() !== exp_pulse ||
          event_pending !== (t >= LAT - 1 && t <= LAT + 1)) begin
        fails++;
        $display("FAIL simultaneous t=%0d: out=%b evp=%b want %b", t, obs(), event_pending, want);
      end
    end
    idle(2 * LAT + 4);
  endtask

  task automatic test_reset_mid();
    int np = 0;
    moneyin_raw = 4'b0100;
    for (int t = 0; t < 3; t++) tick();
    reset_n = 1'b0;
    model_reset();
    #1;
    for (int t = 0; t < 3; t++) begin
      checks++;
      if ({refund, moneyin, buy, event_pending} !== 10'b0) begin
        fails++;
        $display("FAIL reset_mid_hold t=%0d: got %b want 0", t, {refund, moneyin, buy, event_pending});
      end
      tick();
    end
    reset_n = 1'b1;
    for (int t = 0; t < LAT + 6; t++) begin
      tick();
      np += $countones(obs());
      checks++;
      if (obs() !== exp_pulse || moneyin !== ((t == LAT) ? 4'b0100 : 4'b0000)) begin
        fails++;
        $display("FAIL reset_mid t=%0d: moneyin=%b out=%b want %b", t, moneyin, obs(), exp_pulse);
      end
    end
    checks++;
    if (np != 1) begin fails++; $display("FAIL reset_mid_count: got %0d want 1", np); end
    idle(2 * LAT + 4);
  endtask

  task automatic test_hold();
    int np = 0;
    for (int t = 0; t < 70; t++) begin
      buy_raw[1] = (t < 50);
      tick();
      np += $countones(obs());
      checks++;
      if (obs() !== exp_pulse || event_pending !== exp_evp) begin
        fails++;
        $display("FAIL hold t=%0d: out=%b evp=%b want %b %b", t, obs(), event_pending, exp_pulse, exp_evp);
      end
    end
    checks++;
    if (np != 1) begin fails++; $display("FAIL hold_count: got %0d want 1", np); end
  endtask

  task automatic test_random();
    logic [NCH-1:0] r, o;
    int rst_left = 0;
    for (int t = 0; t < 3000; t++) begin
      r = {refund_raw, moneyin_raw, buy_raw};
      for (int k = 0; k < NCH; k++) if ($urandom_range(0, 11) == 0) r[k] = ~r[k];
      {refund_raw, moneyin_raw, buy_raw} = r;
      if (rst_left > 0) begin
        rst_left--;
        if (rst_left == 0) reset_n = 1'b1;
      end else if ($urandom_range(0, 499) == 0) begin
        reset_n = 1'b0;
        model_reset();
        rst_left = 2;
      end
      tick();
      o = obs();
      checks++;
      if (o !== exp_pulse || event_pending !== exp_evp || (o & (o - 1'b1)) != '0) begin
        fails++;
        $display("FAIL random t=%0d: out=%b evp=%b want %b %b", t, o, event_pending, exp_pulse, exp_evp);
      end
    end
    reset_n = 1'b1;
    idle(2 * LAT + 4);
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_simultaneous();
    test_reset_mid();
    test_hold();
    test_random();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
